memory_regfile: RTL and testbench
=================================

MEMORY_REGFILE -- requirements
Module: memory_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of words (2..256).
REQ-003 The block SHALL have parameter AW, default $clog2(DEPTH), meaning address width.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, meaning reset; synchronous, active-high.
REQ-006 The block SHALL have port we, input, 1 bit, meaning write request.
REQ-007 The block SHALL have port waddr, input, AW bits, meaning write address.
REQ-008 The block SHALL have port wdata, input, WIDTH bits, meaning write data.
REQ-009 The block SHALL have port wbe, input, WIDTH/8 bits, meaning byte-lane enables; bit i covers wdata[8i+7:8i].
REQ-010 The block SHALL have port wr_ok, output, 1 bit, meaning the write is accepted this cycle (combinational).
REQ-011 The block SHALL have ports re0 and re1, input, 1 bit each, meaning read enables for ports 0 and 1.
REQ-012 The block SHALL have ports raddr0 and raddr1, input, AW bits each, meaning read addresses.
REQ-013 The block SHALL have ports rdata0 and rdata1, output, WIDTH bits each, meaning registered read data.
REQ-014 The block SHALL have port clr, input, 1 bit, meaning a request to start a bulk clear.
REQ-015 The block SHALL have port busy, output, 1 bit, meaning a clear is in progress.

Function
REQ-016 wr_ok SHALL equal we & ~busy & ~clr & (waddr < DEPTH).
REQ-017 When wr_ok=1, each lane i of mem[waddr] with wbe[i]=1 SHALL take wdata lane i at the clock edge; lanes with wbe[i]=0 SHALL be unchanged.
REQ-018 wbe=0 with wr_ok=1 SHALL leave memory unchanged; it still counts as accepted.
REQ-019 When re_k=1, rdata_k SHALL load mem[raddr_k] at the edge, giving 1-cycle latency; when re_k=0, rdata_k SHALL hold its value.
REQ-020 A read with raddr_k >= DEPTH SHALL load 0.
REQ-021 Reads SHALL be write-first: a read of the address written in the same cycle returns the merged post-write word (new enabled lanes, old other lanes).
REQ-022 Both read ports SHALL operate independently and may read the same address in the same cycle.
REQ-023 The clear FSM SHALL have exactly two states, IDLE and CLEAR, and an AW-bit counter cnt.
REQ-024 In IDLE, clr=1 SHALL cause a transition to CLEAR with cnt=0 at the next edge; any write requested in that cycle SHALL be dropped (clr has priority).
REQ-025 In CLEAR, each cycle SHALL zero mem[cnt] at the edge and increment cnt.
REQ-026 CLEAR SHALL return to IDLE at the edge where cnt==DEPTH-1 is cleared, so that busy=1 for exactly DEPTH cycles.
REQ-027 busy SHALL be 1 if and only if state==CLEAR.
REQ-028 clr asserted while in CLEAR SHALL be ignored; the clear neither restarts nor extends.
REQ-029 Writes SHALL be ignored while busy, with wr_ok=0.
REQ-030 Reads SHALL remain serviced while busy: uncleared entries return their old value, cleared entries return 0, and the entry being cleared in the same cycle returns 0 (write-first).
REQ-031 clr asserted in the cycle after busy falls SHALL start a new clear normally.

Reset
REQ-032 rst=1 at an edge SHALL set all mem words to 0, rdata0=0, rdata1=0, state=IDLE, busy=0 and cnt=0.
REQ-033 rst SHALL override we, re0, re1 and clr in the same cycle.
REQ-034 rst asserted mid-clear SHALL abort the clear; the next cycle is IDLE with all memory 0.
REQ-035 wr_ok SHALL be 0 during a reset cycle.

Verification (WIDTH=16, DEPTH=8)
REQ-036 The bench SHALL cover this scenario: after reset, read both ports at addresses 0..7 -> all rdata 0, busy=0.
REQ-037 The bench SHALL cover this scenario: write addr 3 = 0xA55A with wbe=11, then write addr 3 = 0x00FF with wbe=01, then read addr 3 -> 0xA5FF one cycle after re.
REQ-038 The bench SHALL cover this scenario: in the same cycle write addr 5 = 0x1234 with wbe=11 and re0 with raddr0=5 -> rdata0=0x1234 at the next edge; re1=0 -> rdata1 holds its previous value.
REQ-039 The bench SHALL cover this scenario: fill addresses 0..7 with 0x1111*(addr+1), pulse clr together with we to addr 2 -> write dropped (wr_ok=0), busy=1 for exactly 8 cycles; re0 at addr 7 during the third CLEAR cycle -> 0x8888; after busy falls all reads return 0.
REQ-040 The bench SHALL cover this scenario: start a clear, assert we (wr_ok=0) and clr again during the fourth CLEAR cycle, then assert rst during the fifth -> next cycle busy=0 and all reads return 0; a subsequent write to addr 1 = 0xBEEF reads back 0xBEEF.

Source files
------------

// File: rtl/memory_regfile.sv
// Dual-read, single-write register file with byte-lane write enables,
// write-first reads and a one-word-per-cycle bulk clear engine.
module memory_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wbe,
    output logic               wr_ok,
    input  logic               re0,
    input  logic [AW-1:0]      raddr0,
    output logic [WIDTH-1:0]   rdata0,
    input  logic               re1,
    input  logic [AW-1:0]      raddr1,
    output logic [WIDTH-1:0]   rdata1,
    input  logic               clr,
    output logic               busy
);

    localparam int              LANES   = WIDTH / 8;
    localparam logic [AW:0]     DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state, state_next;
    logic [AW-1:0]    cnt, cnt_next;
    logic             waddr_ok;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rnext0, rnext1;

    assign busy     = (state == CLEAR);
    assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
    assign wr_ok    = we & ~busy & ~clr & waddr_ok & ~rst;

    // Post-write word at waddr: enabled lanes from wdata, the rest kept.
    always_comb begin
        merged = '0;
        if (waddr_ok) begin
            merged = mem[waddr];
        end
        for (int i = 0; i < LANES; i++) begin
            if (wbe[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Value an address will hold after this edge, so reads see same-cycle
    // writes and clears (the clear slot and a write never coincide).
    function automatic logic [WIDTH-1:0] post_edge(input logic [AW-1:0] addr,
                                                   input logic [WIDTH-1:0] word);
        if ({1'b0, addr} >= DEPTH_W) begin
            return '0;
        end
        if (busy && (addr == cnt)) begin
            return '0;
        end
        if (wr_ok && (addr == waddr)) begin
            return merged;
        end
        return word;
    endfunction

    always_comb begin
        rnext0 = post_edge(raddr0, mem[raddr0]);
        rnext1 = post_edge(raddr1, mem[raddr1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (wr_ok) begin
                mem[waddr] <= merged;
            end
            if (busy) begin
                mem[cnt] <= '0;
            end
            if (re0) begin
                rdata0 <= rnext0;
            end
            if (re1) begin
                rdata1 <= rnext1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A clear walks cnt from 0 to DEPTH-1 and cannot be restarted meanwhile.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_regfile.sv
// Bench for memory_regfile (WIDTH=16, DEPTH=8): directed table, clear/reset
// sequences and random traffic against an array-based reference model.
module tb_memory_regfile;

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  wbe;
        logic        re0;
        logic [2:0]  raddr0;
        logic        re1;
        logic [2:0]  raddr1;
        logic        clr;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        exp_wr_ok;
        logic [15:0] exp_r0;
        logic [15:0] exp_r1;
        logic        exp_busy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wbe;
    logic        wr_ok;
    logic        re0;
    logic [2:0]  raddr0;
    logic [15:0] rdata0;
    logic        re1;
    logic [2:0]  raddr1;
    logic [15:0] rdata1;
    logic        clr;
    logic        busy;

    int vec_count  = 0;
    int miscompares = 0;

    // Reference state
    logic [15:0] m_mem [8];
    logic [15:0] m_r0, m_r1;
    bit          m_busy;
    int          m_cnt;

    logic seen_wr_ok;
    logic seen_busy;

    memory_regfile #(.WIDTH(16), .DEPTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .wbe    (wbe),
        .wr_ok  (wr_ok),
        .re0    (re0),
        .raddr0 (raddr0),
        .rdata0 (rdata0),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .clr    (clr),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(logic r, logic w, logic [2:0] wa, logic [15:0] wd,
                                 logic [1:0] be, logic e0, logic [2:0] a0,
                                 logic e1, logic [2:0] a1, logic c);
        stim_t s;
        s.rst = r; s.we = w; s.waddr = wa; s.wdata = wd; s.wbe = be;
        s.re0 = e0; s.raddr0 = a0; s.re1 = e1; s.raddr1 = a1; s.clr = c;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 16'h0, 2'b00, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic model_wr_ok(stim_t s);
        return s.we && !m_busy && !s.clr && !s.rst;
    endfunction

    task automatic model_step(input stim_t s);
        logic ok;
        ok = model_wr_ok(s);
        if (s.rst) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
            m_r0 = 16'h0;
            m_r1 = 16'h0;
            m_busy = 0;
            m_cnt = 0;
        end else begin
            if (ok) begin
                for (int b = 0; b < 2; b++)
                    if (s.wbe[b]) m_mem[s.waddr][8*b +: 8] = s.wdata[8*b +: 8];
            end
            if (m_busy) m_mem[m_cnt] = 16'h0;
            if (s.re0) m_r0 = m_mem[s.raddr0];
            if (s.re1) m_r1 = m_mem[s.raddr1];
            if (m_busy) begin
                if (m_cnt == 7) m_busy = 0;
                else m_cnt = m_cnt + 1;
            end else if (s.clr) begin
                m_busy = 1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, sample wr_ok/busy before the
    // rising edge, then compare registered outputs just after it.
    task automatic applyStimulus(input stim_t s);
        logic exp_ok;
        @(negedge clk);
        rst = s.rst; we = s.we; waddr = s.waddr; wdata = s.wdata; wbe = s.wbe;
        re0 = s.re0; raddr0 = s.raddr0; re1 = s.re1; raddr1 = s.raddr1; clr = s.clr;
        #1;
        seen_wr_ok = wr_ok;
        seen_busy  = busy;
        exp_ok = model_wr_ok(s);
        checkOutput("model wr_ok", {15'h0, wr_ok}, {15'h0, exp_ok});
        @(posedge clk);
        #1;
        model_step(s);
        checkOutput("model rdata0", rdata0, m_r0);
        checkOutput("model rdata1", rdata1, m_r1);
        checkOutput("model busy", {15'h0, busy}, {15'h0, m_busy});
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        int   busy_cycles;
        stim_t s;

        rst = 1; we = 0; waddr = 0; wdata = 0; wbe = 0;
        re0 = 0; raddr0 = 0; re1 = 0; raddr1 = 0; clr = 0;
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
        m_r0 = 0; m_r1 = 0; m_busy = 0; m_cnt = 0;

        // Directed table
        v.s = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        v.exp_wr_ok = 0; v.exp_r0 = 0; v.exp_r1 = 0; v.exp_busy = 0; tbl.push_back(v);
        for (int a = 0; a < 8; a++) begin
            v.s = mk(0, 0, 0, 0, 2'b00, 1, 3'(a), 1, 3'(7 - a), 0);
            v.exp_wr_ok = 0; v.exp_r0 = 0; v.exp_r1 = 0; v.exp_busy = 0; tbl.push_back(v);
        end
        v.s = mk(0, 1, 3, 16'hA55A, 2'b11, 0, 0, 0, 0, 0);
        v.exp_wr_ok = 1; v.exp_r0 = 0; v.exp_r1 = 0; v.exp_busy = 0; tbl.push_back(v);
        v.s = mk(0, 1, 3, 16'h00FF, 2'b01, 0, 0, 0, 0, 0);
        v.exp_wr_ok = 1; v.exp_r0 = 0; v.exp_r1 = 0; v.exp_busy = 0; tbl.push_back(v);
        v.s = mk(0, 0, 0, 0, 2'b00, 1, 3, 1, 3, 0);
        v.exp_wr_ok = 0; v.exp_r0 = 16'hA5FF; v.exp_r1 = 16'hA5FF; v.exp_busy = 0; tbl.push_back(v);
        v.s = mk(0, 1, 5, 16'h1234, 2'b11, 1, 5, 0, 0, 0);
        v.exp_wr_ok = 1; v.exp_r0 = 16'h1234; v.exp_r1 = 16'hA5FF; v.exp_busy = 0; tbl.push_back(v);
        v.s = mk(0, 1, 3, 16'hFFFF, 2'b00, 0, 0, 1, 3, 0);
        v.exp_wr_ok = 1; v.exp_r0 = 16'h1234; v.exp_r1 = 16'hA5FF; v.exp_busy = 0; tbl.push_back(v);
        v.s = mk(0, 1, 3, 16'h1200, 2'b10, 1, 3, 0, 0, 0);
        v.exp_wr_ok = 1; v.exp_r0 = 16'h12FF; v.exp_r1 = 16'hA5FF; v.exp_busy = 0; tbl.push_back(v);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].s);
            checkOutput("tbl wr_ok", {15'h0, seen_wr_ok}, {15'h0, tbl[i].exp_wr_ok});
            checkOutput("tbl rdata0", rdata0, tbl[i].exp_r0);
            checkOutput("tbl rdata1", rdata1, tbl[i].exp_r1);
            checkOutput("tbl busy", {15'h0, busy}, {15'h0, tbl[i].exp_busy});
        end

        // Fill, then clear with a colliding write
        for (int a = 0; a < 8; a++)
            applyStimulus(mk(0, 1, 3'(a), 16'(16'h1111 * (a + 1)), 2'b11, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 1, 2, 16'hFFFF, 2'b11, 0, 0, 0, 0, 1));
        checkOutput("clr write dropped", {15'h0, seen_wr_ok}, 16'h0);
        busy_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            s = idle();
            if (i == 2) begin
                s.re0 = 1; s.raddr0 = 7;
            end
            applyStimulus(s);
            if (seen_busy === 1'b1) busy_cycles++;
            if (i == 2) checkOutput("read during clear", rdata0, 16'h8888);
        end
        checkOutput("busy cycles", 16'(busy_cycles), 16'd8);
        for (int a = 0; a < 8; a++) begin
            applyStimulus(mk(0, 0, 0, 0, 2'b00, 1, 3'(a), 1, 3'(a), 0));
            checkOutput("post-clear rdata0", rdata0, 16'h0);
            checkOutput("post-clear rdata1", rdata1, 16'h0);
        end

        // Ignored re-clear and write mid-clear, then reset aborts it
        for (int a = 0; a < 8; a++)
            applyStimulus(mk(0, 1, 3'(a), 16'hC0DE, 2'b11, 0, 0, 0, 0, 0));
        applyStimulus(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) applyStimulus(idle());
        applyStimulus(mk(0, 1, 6, 16'h5555, 2'b11, 0, 0, 0, 0, 1));
        checkOutput("write while busy", {15'h0, seen_wr_ok}, 16'h0);
        checkOutput("busy 4th cycle", {15'h0, seen_busy}, 16'h1);
        applyStimulus(mk(1, 1, 6, 16'h5555, 2'b11, 1, 7, 1, 6, 1));
        checkOutput("busy after rst", {15'h0, busy}, 16'h0);
        for (int a = 0; a < 8; a++) begin
            applyStimulus(mk(0, 0, 0, 0, 2'b00, 1, 3'(a), 1, 3'(7 - a), 0));
            checkOutput("post-rst rdata0", rdata0, 16'h0);
            checkOutput("post-rst rdata1", rdata1, 16'h0);
            checkOutput("post-rst busy", {15'h0, busy}, 16'h0);
        end
        applyStimulus(mk(0, 1, 1, 16'hBEEF, 2'b11, 0, 0, 0, 0, 0));
        checkOutput("write after rst ok", {15'h0, seen_wr_ok}, 16'h1);
        applyStimulus(mk(0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0));
        checkOutput("readback BEEF", rdata0, 16'hBEEF);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            s.rst    = ($urandom_range(0, 59) == 0);
            s.we     = $urandom_range(0, 1) != 0;
            s.waddr  = 3'($urandom_range(0, 7));
            s.wdata  = 16'($urandom);
            s.wbe    = 2'($urandom_range(0, 3));
            s.re0    = $urandom_range(0, 2) != 0;
            s.raddr0 = 3'($urandom_range(0, 7));
            s.re1    = $urandom_range(0, 2) != 0;
            s.raddr1 = 3'($urandom_range(0, 7));
            s.clr    = ($urandom_range(0, 24) == 0);
            applyStimulus(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
